// File: rtl/rv32i_regfile_sb.sv
// RV32I architectural register file with a per-register pending-write scoreboard.
// Optional write-first forwarding on the read ports when REGFILE_BYPASS_EN is defined.
module rv32i_regfile_sb #(
    parameter int unsigned PEND_W = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_en,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    input  logic [4:0]  rs1_reg,
    input  logic [4:0]  rs2_reg,
    input  logic        rs1_used,
    input  logic        rs2_used,
    input  logic        issue_en,
    input  logic [4:0]  issue_reg,
    input  logic        flush,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        stall,
    output logic        sb_full
);

    localparam logic [PEND_W-1:0] PendMax = '1;

    logic [31:0]       regs_q [1:31];
    logic [PEND_W-1:0] pend_q [1:31];
    logic [PEND_W-1:0] pend_d [1:31];

    logic [4:0]        rs_reg   [2];
    logic [31:0]       rs_data  [2];
    logic              rs_busy  [2];
    logic [PEND_W-1:0] eff_pend [2];

    logic wb_hit;
    logic issue_ok;
    logic dec_ok;

    assign rs_reg[0] = rs1_reg;
    assign rs_reg[1] = rs2_reg;

    // Qualified by reset so forwarding cannot leak wb_data while reset is held.
    assign wb_hit = reset && wb_en && (wb_reg != 5'd0);

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rs_data[p]  = '0;
            rs_busy[p]  = 1'b0;
            eff_pend[p] = '0;
            if (rs_reg[p] != 5'd0) begin
                rs_data[p]  = regs_q[rs_reg[p]];
                eff_pend[p] = pend_q[rs_reg[p]];
`ifdef REGFILE_BYPASS_EN
                // A retiring write releases its own hazard in the same cycle.
                if (wb_hit && (wb_reg == rs_reg[p])) begin
                    rs_data[p] = wb_data;
                    if (eff_pend[p] != '0) begin
                        eff_pend[p] = eff_pend[p] - 1'b1;
                    end
                end
`endif
                rs_busy[p] = (eff_pend[p] != '0);
            end
        end
    end

    assign rs1_data = rs_data[0];
    assign rs2_data = rs_data[1];
    assign rs1_busy = rs_busy[0];
    assign rs2_busy = rs_busy[1];

    always_comb begin
        sb_full = 1'b0;
        if (issue_reg != 5'd0) begin
            sb_full = (pend_q[issue_reg] == PendMax);
        end
    end

    assign stall    = (rs1_used && rs1_busy) || (rs2_used && rs2_busy) || sb_full;
    assign issue_ok = issue_en && (issue_reg != 5'd0) && !stall;

    always_comb begin
        dec_ok = 1'b0;
        if (wb_en && (wb_reg != 5'd0)) begin
            dec_ok = (pend_q[wb_reg] != '0);
        end
    end

    always_comb begin
        for (int r = 1; r < 32; r++) begin
            pend_d[r] = pend_q[r];
            if (flush) begin
                pend_d[r] = '0;
            end else if (issue_ok && (issue_reg == 5'(r)) && !(dec_ok && (wb_reg == 5'(r)))) begin
                pend_d[r] = pend_q[r] + 1'b1;
            end else if (dec_ok && (wb_reg == 5'(r)) && !(issue_ok && (issue_reg == 5'(r)))) begin
                pend_d[r] = pend_q[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 1; r < 32; r++) begin
                regs_q[r] <= '0;
                pend_q[r] <= '0;
            end
        end else begin
            if (wb_en && (wb_reg != 5'd0)) begin
                regs_q[wb_reg] <= wb_data;
            end
            for (int r = 1; r < 32; r++) begin
                pend_q[r] <= pend_d[r];
            end
        end
    end

endmodule

// File: tb/tb_rv32i_regfile_sb.sv
// Self-checking bench for rv32i_regfile_sb: directed plan steps plus randomized traffic
// against an array-based reference model. Honours REGFILE_BYPASS_EN like the design.
module tb_rv32i_regfile_sb;

    localparam int unsigned PEND_W = 3;
    localparam int PMAX = (1 << PEND_W) - 1;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic [4:0]  rs1_reg;
    logic [4:0]  rs2_reg;
    logic        rs1_used;
    logic        rs2_used;
    logic        issue_en;
    logic [4:0]  issue_reg;
    logic        flush;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        stall;
    logic        sb_full;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [32];
    int          m_pend [32];

    always #5 clk = ~clk;

    rv32i_regfile_sb #(.PEND_W(PEND_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .wb_en     (wb_en),
        .wb_reg    (wb_reg),
        .wb_data   (wb_data),
        .rs1_reg   (rs1_reg),
        .rs2_reg   (rs2_reg),
        .rs1_used  (rs1_used),
        .rs2_used  (rs2_used),
        .issue_en  (issue_en),
        .issue_reg (issue_reg),
        .flush     (flush),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .stall     (stall),
        .sb_full   (sb_full)
    );

    function automatic logic wb_hits(input logic [4:0] r);
        return reset && wb_en && (wb_reg != 5'd0) && (wb_reg == r);
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] r);
        if (!reset || r == 5'd0) return 32'd0;
        if (BYP && wb_hits(r)) return wb_data;
        return m_regs[r];
    endfunction

    function automatic logic exp_busy(input logic [4:0] r);
        int p;
        if (!reset || r == 5'd0) return 1'b0;
        p = m_pend[r];
        if (BYP && wb_hits(r) && p > 0) p = p - 1;
        return p != 0;
    endfunction

    function automatic logic exp_full();
        return reset && (issue_reg != 5'd0) && (m_pend[issue_reg] == PMAX);
    endfunction

    function automatic logic exp_stall();
        return (rs1_used && exp_busy(rs1_reg)) || (rs2_used && exp_busy(rs2_reg)) || exp_full();
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/rs1_data"}, rs1_data, exp_data(rs1_reg));
        chk({tag, "/rs2_data"}, rs2_data, exp_data(rs2_reg));
        chk({tag, "/rs1_busy"}, 32'(rs1_busy), 32'(exp_busy(rs1_reg)));
        chk({tag, "/rs2_busy"}, 32'(rs2_busy), 32'(exp_busy(rs2_reg)));
        chk({tag, "/sb_full"}, 32'(sb_full), 32'(exp_full()));
        chk({tag, "/stall"}, 32'(stall), 32'(exp_stall()));
    endtask

    // Model state advance, evaluated with the inputs that were present at the edge.
    task automatic model_step();
        logic st, inc, dec;
        st  = exp_stall();
        inc = issue_en && (issue_reg != 5'd0) && !st;
        dec = wb_en && (wb_reg != 5'd0) && (m_pend[wb_reg] > 0);
        if (wb_en && wb_reg != 5'd0) m_regs[wb_reg] = wb_data;
        if (flush) begin
            for (int i = 0; i < 32; i++) m_pend[i] = 0;
        end else if (!(inc && dec && issue_reg == wb_reg)) begin
            if (inc) m_pend[issue_reg] = m_pend[issue_reg] + 1;
            if (dec) m_pend[wb_reg] = m_pend[wb_reg] - 1;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_pend[i] = 0;
        end
    endtask

    task automatic clear_inputs();
        wb_en = 1'b0; wb_reg = 5'd0; wb_data = 32'd0;
        rs1_reg = 5'd0; rs2_reg = 5'd0; rs1_used = 1'b0; rs2_used = 1'b0;
        issue_en = 1'b0; issue_reg = 5'd0; flush = 1'b0;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cycle(input string tag);
        settle();
        check_all(tag);
        tick();
    endtask

    initial begin
        model_reset();
        clear_inputs();
        reset = 1'b0;
        wb_en = 1'b1; wb_reg = 5'd5; wb_data = 32'hA5A5_A5A5;
        rs1_reg = 5'd5; rs1_used = 1'b1; issue_en = 1'b1; issue_reg = 5'd5;
        #1;
        check_all("reset_held");
        chk("reset_held_rs1_const", rs1_data, 32'd0);
        chk("reset_held_stall_const", 32'(stall), 32'd0);
        clear_inputs();
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;

        // Write then read back
        wb_en = 1'b1; wb_reg = 5'd5; wb_data = 32'hDEAD_BEEF;
        cycle("wb_x5");
        clear_inputs();
        rs1_reg = 5'd5; rs2_reg = 5'd0;
        settle();
        check_all("rd_x5");
        chk("rd_x5_const", rs1_data, 32'hDEAD_BEEF);
        chk("rd_x0_const", rs2_data, 32'd0);
        tick();

        // x0 immutability
        clear_inputs();
        wb_en = 1'b1; wb_reg = 5'd0; wb_data = 32'hFFFF_FFFF;
        issue_en = 1'b1; issue_reg = 5'd0; rs1_used = 1'b1;
        cycle("x0_write");
        clear_inputs();
        rs1_used = 1'b1;
        settle();
        check_all("x0_read");
        chk("x0_read_const", rs1_data, 32'd0);
        chk("x0_busy_const", 32'(rs1_busy), 32'd0);
        tick();

        // RAW hazard on x7
        clear_inputs();
        issue_en = 1'b1; issue_reg = 5'd7;
        cycle("raw_issue");
        clear_inputs();
        rs1_reg = 5'd7; rs1_used = 1'b1;
        settle();
        check_all("raw_wait");
        chk("raw_wait_stall", 32'(stall), 32'd1);
        tick();
        wb_en = 1'b1; wb_reg = 5'd7; wb_data = 32'h0000_1234;
        settle();
        check_all("raw_wb");
        chk("raw_wb_stall", 32'(stall), BYP ? 32'd0 : 32'd1);
        chk("raw_wb_data", rs1_data, BYP ? 32'h0000_1234 : 32'd0);
        tick();
        wb_en = 1'b0;
        settle();
        check_all("raw_after");
        chk("raw_after_stall", 32'(stall), 32'd0);
        chk("raw_after_data", rs1_data, 32'h0000_1234);
        tick();

        // Saturation on x3
        clear_inputs();
        issue_en = 1'b1; issue_reg = 5'd3;
        repeat (PMAX) cycle("sat_issue");
        settle();
        check_all("sat_full");
        chk("sat_full_flag", 32'(sb_full), 32'd1);
        chk("sat_full_stall", 32'(stall), 32'd1);
        tick();
        clear_inputs();
        wb_en = 1'b1; wb_reg = 5'd3;
        for (int i = 0; i < PMAX - 1; i++) begin
            wb_data = 32'(i + 100);
            cycle("sat_drain");
        end
        rs1_reg = 5'd3; wb_data = 32'h3333_3333;
        settle();
        check_all("sat_last_wb");
        chk("sat_last_busy", 32'(rs1_busy), BYP ? 32'd0 : 32'd1);
        tick();
        clear_inputs();
        rs1_reg = 5'd3;
        settle();
        check_all("sat_done");
        chk("sat_done_busy", 32'(rs1_busy), 32'd0);
        tick();

        // Simultaneous issue and writeback on x9
        clear_inputs();
        issue_en = 1'b1; issue_reg = 5'd9;
        cycle("x9_issue");
        wb_en = 1'b1; wb_reg = 5'd9; wb_data = 32'h0000_0099; rs1_reg = 5'd9;
        cycle("x9_both");
        clear_inputs();
        rs1_reg = 5'd9; rs1_used = 1'b0;
        settle();
        check_all("x9_after");
        chk("x9_busy", 32'(rs1_busy), 32'd1);
        chk("x9_stall", 32'(stall), 32'd0);
        tick();
        wb_en = 1'b1; wb_reg = 5'd9; wb_data = 32'h0000_0999;
        cycle("x9_drain");

        // Flush
        clear_inputs();
        issue_en = 1'b1; issue_reg = 5'd4;
        cycle("fl_issue0");
        cycle("fl_issue1");
        flush = 1'b1;
        cycle("fl_flush");
        clear_inputs();
        rs1_reg = 5'd4;
        settle();
        check_all("fl_after");
        chk("fl_busy", 32'(rs1_busy), 32'd0);
        tick();
        wb_en = 1'b1; wb_reg = 5'd4; wb_data = 32'hCAFE_0004;
        cycle("fl_late_wb");
        clear_inputs();
        rs1_reg = 5'd4;
        settle();
        check_all("fl_late_rd");
        chk("fl_late_data", rs1_data, 32'hCAFE_0004);
        chk("fl_late_busy", 32'(rs1_busy), 32'd0);
        tick();

        // Randomized traffic over a small register window to provoke hazards
        for (int n = 0; n < 400; n++) begin
            wb_en     = ($urandom_range(0, 2) != 0);
            wb_reg    = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            rs1_reg   = 5'($urandom_range(0, 7));
            rs2_reg   = 5'($urandom_range(0, 7));
            rs1_used  = 1'($urandom_range(0, 1));
            rs2_used  = 1'($urandom_range(0, 1));
            issue_en  = 1'($urandom_range(0, 1));
            issue_reg = 5'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 31) == 0);
            cycle("rand");
        end

        // Async reset in the middle of a stall
        clear_inputs();
        wb_en = 1'b1; wb_reg = 5'd5; wb_data = 32'h5555_AAAA;
        cycle("ar_wb");
        clear_inputs();
        issue_en = 1'b1; issue_reg = 5'd6;
        cycle("ar_issue");
        clear_inputs();
        rs1_reg = 5'd6; rs1_used = 1'b1; rs2_reg = 5'd5;
        settle();
        check_all("ar_pre");
        chk("ar_pre_stall", 32'(stall), 32'd1);
        reset = 1'b0;
        #1;
        model_reset();
        check_all("ar_held");
        chk("ar_stall", 32'(stall), 32'd0);
        chk("ar_rs2_data", rs2_data, 32'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        cycle("ar_post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32i_regfile_sb.md
# rv32i_regfile_sb

Architectural register file and hazard scoreboard for the RV32I pipeline; the receiving end of the writeback interface. Accepts writeback enable/register/data from the writeback stage and serves two combinational read ports to instruction decode. A per-register pending-write counter tracks in-flight destinations issued by decode and drives a stall request until the matching writebacks retire.

## Interface
- PEND_W, 3: width of each per-register pending-write counter; max in-flight writes per register = 2^PEND_W − 1
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- wb_en  in  1  writeback enable from writeback stage
- wb_reg  in  5  writeback destination register
- wb_data  in  32  writeback data
- rs1_reg, rs2_reg  in  5 each  decode source register addresses
- rs1_used, rs2_used  in  1 each  instruction in decode actually reads rs1/rs2
- issue_en  in  1  decode issues an instruction that will write back
- issue_reg  in  5  destination register of issued instruction
- flush  in  1  discard all in-flight writes (pipeline flush)
- rs1_data, rs2_data  out  32 each  source operand values
- rs1_busy, rs2_busy  out  1 each  source has an outstanding write
- stall  out  1  (rs1_used & rs1_busy) | (rs2_used & rs2_busy) | sb_full
- sb_full  out  1  issue_reg counter at maximum; decode must hold

## Operation
- Storage: x1..x31, 32 bits each; x0 not stored, reads 0, writes ignored.
- Write: on rising clk with wb_en=1 and wb_reg≠0, regs[wb_reg] ← wb_data.
- Read: rsN_data combinational; x0 → 0; else regs[rsN_reg] (see Configuration for bypass).
- Scoreboard: pend[r], PEND_W bits, r = 1..31; pend[0] constant 0.
  - Increment: issue_en=1, issue_reg≠0, stall=0.
  - Decrement: wb_en=1, wb_reg≠0, pend[wb_reg]≠0.
  - Both on same register same cycle: unchanged.
  - Decrement at 0: stays 0 (writeback from an instruction issued before flush).
  - Increment at max: blocked; sb_full=1 forces stall, so issue is not accepted.
  - flush=1: all pend ← 0 next edge; overrides any same-cycle issue/decrement. Register data write still occurs.
- Issue qualified by stall: an issue_en asserted while stall=1 does not increment.
- rsN_busy = (rsN_reg≠0) & (effective pend[rsN_reg] ≠ 0).

## Timing
- Reset (reset=0, async): regs 0, pend 0. Outputs while held: rs1_data=rs2_data=0, busy=0, stall=0, sb_full=0. Reset mid-operation discards all writes and pending state immediately.
- Write latency: 1 cycle to array; same-cycle visibility only via bypass.
- Scoreboard update latency: 1 cycle; busy/stall purely combinational from current pend, inputs.
- Read ports and stall have no registered stage; decode samples them in the same cycle.
- Simultaneous wb_en to rsN_reg and rsN read: governed by Configuration.

## Configuration
- REGFILE_BYPASS_EN defined: write-first forwarding. If wb_en & wb_reg≠0 & wb_reg==rsN_reg, rsN_data = wb_data; effective pend for busy = pend − 1 (saturating at 0), so a last pending write retiring this cycle releases the stall in the same cycle.
- Undefined: rsN_data always from array (pre-write value); busy uses raw pend, so stall releases one cycle after final writeback. Decode observes one extra stall cycle per RAW hazard.

## Test plan
- Reset then write: release reset, wb_en=1 wb_reg=5 wb_data=0xDEADBEEF; next cycle rs1_reg=5 → rs1_data=0xDEADBEEF; rs2_reg=0 → 0.
- x0 immutability: wb_en=1 wb_reg=0 wb_data=0xFFFFFFFF; issue_en issue_reg=0 → rs1_reg=0 reads 0, rs1_busy=0, pend unchanged.
- RAW stall: issue_reg=7; next cycle rs1_reg=7 rs1_used=1 → stall=1; wb_en wb_reg=7 data=0x1234 → bypass: same cycle rs1_data=0x1234, stall=0; no bypass: stall=0 one cycle later, data 0x1234.
- Counter saturation (PEND_W=3): issue x3 seven times → sb_full=1 with issue_reg=3, eighth issue not counted; seven writebacks to x3 → busy=0.
- Simultaneous issue+writeback on x9 with pend=1 → pend stays 1, rs busy=1; rs1_used=0 → stall=0 despite busy.
- Flush and async reset: pend x4=2, flush=1 → next cycle busy=0; later wb to x4 leaves pend 0, data written. Assert reset mid-stall → stall and data drop to 0 without a clock edge.
